// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port integer register file with write-through bypass
// and a per-register busy scoreboard. After reset a clear sequencer walks
// every register to zero before the file reports ready.
module reg_file_sb #(
  parameter int XLEN = 64,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 ready,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr0_en,
  input  logic [AW-1:0]        wr0_addr,
  input  logic [XLEN-1:0]      wr0_data,
  input  logic                 wr1_en,
  input  logic [AW-1:0]        wr1_addr,
  input  logic [XLEN-1:0]      wr1_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr
);

  localparam int NREGS = 2**AW;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy_reg, busy_next;

  logic run;
  logic wr0_ok, wr1_ok, alloc_ok;

  assign run   = (state_reg == RUN);
  assign ready = run;

  // Writes and allocs only take effect in RUN, never to x0, and never in a reset cycle.
  assign wr0_ok   = run && !reset && wr0_en   && (wr0_addr   != '0);
  assign wr1_ok   = run && !reset && wr1_en   && (wr1_addr   != '0);
  assign alloc_ok = run && !reset && alloc_en && (alloc_addr != '0);

  // State and clear-counter register; reset restarts the clear walk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: CLEAR steps through every register, then RUN until reset.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {AW{1'b1}}) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // Storage update: clear walk in CLEAR; in RUN port 0 is applied last so it wins a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) begin
        mem[cnt_reg] <= '0;
      end else begin
        if (wr1_ok) begin
          mem[wr1_addr] <= wr1_data;
        end
        if (wr0_ok) begin
          mem[wr0_addr] <= wr0_data;
        end
      end
    end
  end

  // Per-register scoreboard next value: an alloc outranks a same-cycle write clear.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      logic alloc_hit, wr_hit;
      assign alloc_hit = alloc_ok && (alloc_addr == AW'(gi));
      assign wr_hit    = (wr0_ok && (wr0_addr == AW'(gi))) ||
                         (wr1_ok && (wr1_addr == AW'(gi)));
      assign busy_next[gi] = !run     ? ((cnt_reg == AW'(gi)) ? 1'b0 : busy_reg[gi]) :
                             alloc_hit ? 1'b1 :
                             wr_hit    ? 1'b0 : busy_reg[gi];
    end
  endgenerate

  // Scoreboard register; held during a reset cycle, zeroed by the clear walk.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_reg <= busy_next;
    end
  end

  // Read ports: x0 reads zero, then port-0 bypass, port-1 bypass, stored value.
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   ra;
      logic            hit0, hit1;
      logic [XLEN-1:0] rdat;
      assign ra   = rd_addr[gi*AW +: AW];
      assign hit0 = wr0_en && (wr0_addr == ra);
      assign hit1 = wr1_en && (wr1_addr == ra);
      assign rdat = (!run || (ra == '0)) ? '0 :
                    hit0                 ? wr0_data :
                    hit1                 ? wr1_data : mem[ra];
      assign rd_data[gi*XLEN +: XLEN] = rdat;
      // A write landing this cycle resolves the hazard, so it masks busy.
      assign rd_busy[gi] = run && (ra != '0) && busy_reg[ra] && !(hit0 || hit1);
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed table, reset sequences, randomized run
// against an array-based reference, and a small parametrised instance.
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic         reset;
  logic         ready;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic         wr0_en, wr1_en, alloc_en;
  logic [4:0]   wr0_addr, wr1_addr, alloc_addr;
  logic [63:0]  wr0_data, wr1_data;

  reg_file_sb dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  // Small instance: XLEN=32, AW=3, NRD=3
  logic        reset_b;
  logic        ready_b;
  logic [8:0]  rd_addr_b;
  logic [95:0] rd_data_b;
  logic [2:0]  rd_busy_b;
  logic        wr0_en_b, wr1_en_b, alloc_en_b;
  logic [2:0]  wr0_addr_b, wr1_addr_b, alloc_addr_b;
  logic [31:0] wr0_data_b, wr1_data_b;

  reg_file_sb #(.XLEN(32), .AW(3), .NRD(3)) dut_b (
    .clk(clk), .reset(reset_b), .ready(ready_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en_b), .wr0_addr(wr0_addr_b), .wr0_data(wr0_data_b),
    .wr1_en(wr1_en_b), .wr1_addr(wr1_addr_b), .wr1_data(wr1_data_b),
    .alloc_en(alloc_en_b), .alloc_addr(alloc_addr_b)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic idle();
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    alloc_en = 0; alloc_addr = 0;
  endtask

  // Count sampled cycles with ready low until it rises (bounded).
  task automatic count_ready(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready) break;
      n++;
    end
  endtask

  task automatic scan_zero(input string tag);
    for (int a = 0; a < 32; a += 2) begin
      @(posedge clk); #1;
      rd_addr = {5'(a + 1), 5'(a)};
      @(negedge clk);
      chk($sformatf("%s_data_a%0d", tag, a), rd_data, 128'd0);
      chk($sformatf("%s_busy_a%0d", tag, a), {126'd0, rd_busy}, 128'd0);
    end
  endtask

  // Directed vector table
  typedef struct {
    logic        w0e; logic [4:0] w0a; logic [63:0] w0d;
    logic        w1e; logic [4:0] w1a; logic [63:0] w1d;
    logic        ae;  logic [4:0] aa;
    logic [4:0]  r0;  logic [4:0] r1;
    logic [63:0] e0;  logic [63:0] e1;
    logic [1:0]  eb;
  } vec_t;
  vec_t tbl [19];

  // Reference model state
  logic [63:0] m_mem [32];
  bit          m_busy [32];

  function automatic logic [63:0] model_rd(input logic [4:0] a);
    if (a == 0) return 64'd0;
    if (wr0_en && wr0_addr == a) return wr0_data;
    if (wr1_en && wr1_addr == a) return wr1_data;
    return m_mem[a];
  endfunction

  function automatic logic model_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int n;
    reset = 1; rd_addr = 0; idle();
    reset_b = 1; rd_addr_b = 0;
    wr0_en_b = 0; wr0_addr_b = 0; wr0_data_b = 0;
    wr1_en_b = 0; wr1_addr_b = 0; wr1_data_b = 0;
    alloc_en_b = 0; alloc_addr_b = 0;

    //            w0e w0a  w0d       w1e w1a  w1d       ae aa    r0    r1    e0        e1        eb
    tbl[0]  = '{1, 5'd5, 64'h1234, 0, 5'd0, 64'h0,    0, 5'd0, 5'd5, 5'd0, 64'h1234, 64'h0,    2'b00};
    tbl[1]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    0, 5'd0, 5'd5, 5'd0, 64'h1234, 64'h0,    2'b00};
    tbl[2]  = '{0, 5'd0, 64'h0,    1, 5'd0, 64'hFFFF, 0, 5'd0, 5'd0, 5'd5, 64'h0,    64'h1234, 2'b00};
    tbl[3]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    0, 5'd0, 5'd0, 5'd0, 64'h0,    64'h0,    2'b00};
    tbl[4]  = '{1, 5'd7, 64'hAAAA, 1, 5'd7, 64'hBBBB, 0, 5'd0, 5'd7, 5'd7, 64'hAAAA, 64'hAAAA, 2'b00};
    tbl[5]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    0, 5'd0, 5'd7, 5'd5, 64'hAAAA, 64'h1234, 2'b00};
    tbl[6]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    1, 5'd9, 5'd9, 5'd9, 64'h0,    64'h0,    2'b00};
    tbl[7]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    0, 5'd0, 5'd9, 5'd0, 64'h0,    64'h0,    2'b01};
    tbl[8]  = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    0, 5'd0, 5'd9, 5'd9, 64'h0,    64'h0,    2'b11};
    tbl[9]  = '{0, 5'd0, 64'h0,    1, 5'd9, 64'h55,   0, 5'd0, 5'd9, 5'd9, 64'h55,   64'h55,   2'b00};
    tbl[10] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    0, 5'd0, 5'd9, 5'd9, 64'h55,   64'h55,   2'b00};
    tbl[11] = '{1, 5'd9, 64'h66,   0, 5'd0, 64'h0,    1, 5'd9, 5'd9, 5'd9, 64'h66,   64'h66,   2'b00};
    tbl[12] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    0, 5'd0, 5'd9, 5'd9, 64'h66,   64'h66,   2'b11};
    tbl[13] = '{1, 5'd9, 64'h77,   0, 5'd0, 64'h0,    0, 5'd0, 5'd9, 5'd9, 64'h77,   64'h77,   2'b00};
    tbl[14] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    0, 5'd0, 5'd9, 5'd9, 64'h77,   64'h77,   2'b00};
    tbl[15] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    1, 5'd0, 5'd0, 5'd0, 64'h0,    64'h0,    2'b00};
    tbl[16] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    0, 5'd0, 5'd0, 5'd0, 64'h0,    64'h0,    2'b00};
    tbl[17] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    1, 5'd3, 5'd3, 5'd9, 64'h0,    64'h77,   2'b00};
    tbl[18] = '{0, 5'd0, 64'h0,    0, 5'd0, 64'h0,    0, 5'd0, 5'd3, 5'd9, 64'h0,    64'h77,   2'b01};

    // Reset state while reset is held
    @(posedge clk); @(negedge clk);
    chk("reset_ready", {127'd0, ready}, 128'd0);
    chk("reset_data", rd_data, 128'd0);
    chk("reset_busy", {126'd0, rd_busy}, 128'd0);

    // One-cycle reset pulse, then ready latency and all-zero contents
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    count_ready(n);
    chk("ready_latency", 128'(n), 128'd32);
    scan_zero("clr");

    // Directed table
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      wr0_en = tbl[i].w0e; wr0_addr = tbl[i].w0a; wr0_data = tbl[i].w0d;
      wr1_en = tbl[i].w1e; wr1_addr = tbl[i].w1a; wr1_data = tbl[i].w1d;
      alloc_en = tbl[i].ae; alloc_addr = tbl[i].aa;
      rd_addr = {tbl[i].r1, tbl[i].r0};
      @(negedge clk);
      chk($sformatf("tbl%0d_d0", i), {64'd0, rd_data[63:0]}, {64'd0, tbl[i].e0});
      chk($sformatf("tbl%0d_d1", i), {64'd0, rd_data[127:64]}, {64'd0, tbl[i].e1});
      chk($sformatf("tbl%0d_busy", i), {126'd0, rd_busy}, {126'd0, tbl[i].eb});
    end

    // Reset mid-operation (busy bit 3 set, data live), re-reset at CLEAR cycle 10,
    // with writes and allocs to x1 pulsed throughout the clear walk
    @(posedge clk); #1 idle(); reset = 1;
    @(posedge clk); #1 reset = 0;
    wr0_en = 1; wr0_addr = 5'd1; wr0_data = 64'hDEAD;
    alloc_en = 1; alloc_addr = 5'd1;
    rd_addr = {5'd3, 5'd1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("clr_ready_c%0d", i), {127'd0, ready}, 128'd0);
      chk($sformatf("clr_data_c%0d", i), rd_data, 128'd0);
      chk($sformatf("clr_busy_c%0d", i), {126'd0, rd_busy}, 128'd0);
    end
    reset = 1;
    @(posedge clk); #1 reset = 0;
    count_ready(n);
    idle();
    chk("rereset_latency", 128'(n), 128'd32);
    scan_zero("rclr");

    // Randomized run against reference model (contents are all zero here)
    for (int a = 0; a < 32; a++) begin m_mem[a] = 0; m_busy[a] = 0; end
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = rnd_addr(); wr0_data = {$urandom, $urandom};
      wr1_en = 1'($urandom_range(0, 1)); wr1_addr = rnd_addr(); wr1_data = {$urandom, $urandom};
      alloc_en = 1'($urandom_range(0, 1)); alloc_addr = rnd_addr();
      rd_addr = {rnd_addr(), rnd_addr()};
      @(negedge clk);
      chk($sformatf("rnd%0d_d0", c), {64'd0, rd_data[63:0]}, {64'd0, model_rd(rd_addr[4:0])});
      chk($sformatf("rnd%0d_d1", c), {64'd0, rd_data[127:64]}, {64'd0, model_rd(rd_addr[9:5])});
      chk($sformatf("rnd%0d_busy", c), {126'd0, rd_busy},
          {126'd0, model_busy(rd_addr[9:5]), model_busy(rd_addr[4:0])});
      if (wr1_en && wr1_addr != 0) begin m_mem[wr1_addr] = wr1_data; m_busy[wr1_addr] = 0; end
      if (wr0_en && wr0_addr != 0) begin m_mem[wr0_addr] = wr0_data; m_busy[wr0_addr] = 0; end
      if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1;
    end
    @(posedge clk); #1 idle();

    // Parametrised instance: 8-register clear, then three independent reads
    reset_b = 0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready_b) break;
      n++;
    end
    chk("b_ready_latency", 128'(n), 128'd8);
    @(posedge clk); #1;
    wr0_en_b = 1; wr0_addr_b = 3'd1; wr0_data_b = 32'h11;
    wr1_en_b = 1; wr1_addr_b = 3'd2; wr1_data_b = 32'h22;
    @(posedge clk); #1;
    wr0_addr_b = 3'd3; wr0_data_b = 32'h33; wr1_en_b = 0;
    @(posedge clk); #1;
    wr0_en_b = 0;
    rd_addr_b = {3'd3, 3'd2, 3'd1};
    @(negedge clk);
    chk("b_rd0", {96'd0, rd_data_b[31:0]}, 128'h11);
    chk("b_rd1", {96'd0, rd_data_b[63:32]}, 128'h22);
    chk("b_rd2", {96'd0, rd_data_b[95:64]}, 128'h33);
    chk("b_busy", {125'd0, rd_busy_b}, 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
